// File: rtl/alu_share_arbiter_pkg.sv
// Shared opcode and FSM encodings for the shared-ALU arbiter and processor control path.
package alu_share_arbiter_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Round-robin pick between two requesters; a tie goes to whoever was not granted last.
  function automatic logic rr_pick(input logic [1:0] valid, input logic last_grant);
    return (valid == 2'b11) ? ~last_grant : valid[1];
  endfunction

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Purely combinational ALU shared by both requesters; illegal opcodes yield zero with err set.
module alu_compute
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             err
);

  always_comb begin
    out = '0;
    err = 1'b0;
    case (op)
      OP_AND:  out = a & b;
      OP_OR:   out = a | b;
      OP_ADD:  out = a + b;
      OP_SUB:  out = a - b;
      OP_SLT:  out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: err = 1'b1;
    endcase
    zero = (out == '0);
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end for a single ALU: accept, execute, then hold the
// response until the consumer takes it.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req0_op,
  input  logic [3:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_zero,
  output logic             rsp_id,
  output logic             rsp_err
);

  logic [1:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [3:0]       op_code_q, op_code_d;
  logic             op_id_q, op_id_d;
  logic [WIDTH-1:0] rsp_out_q, rsp_out_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_err_q, rsp_err_d;

  logic             grant_id;
  logic             accept;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;
  logic             alu_err;

  alu_compute #(.WIDTH(WIDTH)) u_alu (
    .a    (op_a_q),
    .b    (op_b_q),
    .op   (op_code_q),
    .out  (alu_out),
    .zero (alu_zero),
    .err  (alu_err)
  );

  // Accept is gated by reset so no requester sees ready while the block is held in reset.
  assign grant_id  = rr_pick(req_valid, last_grant_q);
  assign accept    = (state_q == ST_IDLE) && reset && (req_valid != 2'b00);
  assign req_ready = accept ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_out   = rsp_out_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_code_d    = op_code_q;
    op_id_d      = op_id_q;
    rsp_out_d    = rsp_out_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_id_d     = rsp_id_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_a_d       = grant_id ? req1_a  : req0_a;
          op_b_d       = grant_id ? req1_b  : req0_b;
          op_code_d    = grant_id ? req1_op : req0_op;
          op_id_d      = grant_id;
          last_grant_d = grant_id;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_out_d  = alu_out;
        rsp_zero_d = alu_zero;
        rsp_err_d  = alu_err;
        rsp_id_d   = op_id_q;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_code_q    <= OP_AND;
      op_id_q      <= 1'b0;
      rsp_out_q    <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_code_q    <= op_code_d;
      op_id_q      <= op_id_d;
      rsp_out_q    <= rsp_out_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: hand-computed vectors checked with immediate assertions.
module tb_alu_share_arbiter;

  logic        clock;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_out;
  logic        rsp_zero;
  logic        rsp_id;
  logic        rsp_err;

  int compared;
  int mismatched;

  alu_share_arbiter #(.WIDTH(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req0_op   (req0_op),
    .req1_op   (req1_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_out   (rsp_out),
    .rsp_zero  (rsp_zero),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] valid,
                               input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] op0,
                               input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] op1);
    req_valid = valid;
    req0_a = a0; req0_b = b0; req0_op = op0;
    req1_a = a1; req1_b = b1; req1_op = op1;
  endtask

  // One full transaction from a single requester, with the inputs scrambled after acceptance.
  task automatic runOp(input string tag, input logic [1:0] valid,
                       input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                       input logic [31:0] exp_out, input logic exp_zero, input logic exp_err);
    applyStimulus(valid, a, b, op, a, b, op);
    #1;
    checkOutput({tag, "_ready"}, {30'd0, req_ready}, {30'd0, valid});
    tick();
    applyStimulus(2'b00, 32'hDEAD_BEEF, 32'h1234_5678, 4'd1, 32'hDEAD_BEEF, 32'h1234_5678, 4'd1);
    checkOutput({tag, "_exec_valid"}, {31'd0, rsp_valid}, 32'd0);
    tick();
    checkOutput({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    checkOutput({tag, "_out"},   rsp_out, exp_out);
    checkOutput({tag, "_zero"},  {31'd0, rsp_zero}, {31'd0, exp_zero});
    checkOutput({tag, "_err"},   {31'd0, rsp_err},  {31'd0, exp_err});
    checkOutput({tag, "_id"},    {31'd0, rsp_id},   {31'd0, valid[1]});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput({tag, "_idle_valid"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b0;
    rsp_ready  = 1'b0;
    applyStimulus(2'b00, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0);
    tick();
    tick();

    // Reset state, and no ready while reset is low even with a request pending.
    checkOutput("rst_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_out",   rsp_out, 32'd0);
    checkOutput("rst_zero",  {31'd0, rsp_zero}, 32'd0);
    checkOutput("rst_id",    {31'd0, rsp_id}, 32'd0);
    checkOutput("rst_err",   {31'd0, rsp_err}, 32'd0);
    applyStimulus(2'b11, 32'd1, 32'd1, 4'd2, 32'd1, 32'd1, 4'd2);
    #1;
    checkOutput("rst_ready", {30'd0, req_ready}, 32'd0);
    applyStimulus(2'b00, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0);
    reset = 1'b1;
    tick();

    // Single request, latency two cycles.
    runOp("add_5_3", 2'b01, 32'd5, 32'd3, 4'd2, 32'd8, 1'b0, 1'b0);

    // Tie after reset: grants alternate 0,1,0,1 with accepts every three cycles.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    rsp_ready = 1'b1;
    applyStimulus(2'b11, 32'd1, 32'd2, 4'd2, 32'd10, 32'd4, 4'd6);
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput("tie_grant", {30'd0, req_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      checkOutput("tie_exec_ready", {30'd0, req_ready}, 32'd0);
      tick();
      checkOutput("tie_resp_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("tie_resp_ready", {30'd0, req_ready}, 32'd0);
      checkOutput("tie_id",  {31'd0, rsp_id}, (k % 2 == 0) ? 32'd0 : 32'd1);
      checkOutput("tie_out", rsp_out, (k % 2 == 0) ? 32'd3 : 32'd6);
      tick();
    end
    rsp_ready = 1'b0;
    applyStimulus(2'b00, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0);

    // Opcode coverage including wrap, signed compare and illegal codes.
    runOp("sub_zero",  2'b10, 32'd7, 32'd7, 4'd6, 32'd0, 1'b1, 1'b0);
    runOp("slt_neg",   2'b01, 32'hFFFF_FFFF, 32'd1, 4'd7, 32'd1, 1'b0, 1'b0);
    runOp("slt_pos",   2'b10, 32'd1, 32'hFFFF_FFFF, 4'd7, 32'd0, 1'b1, 1'b0);
    runOp("and",       2'b01, 32'h0000_F0F0, 32'h0000_0FF0, 4'd0, 32'h0000_00F0, 1'b0, 1'b0);
    runOp("or",        2'b10, 32'h0000_F000, 32'h0000_000F, 4'd1, 32'h0000_F00F, 1'b0, 1'b0);
    runOp("add_wrap",  2'b01, 32'hFFFF_FFFF, 32'd2, 4'd2, 32'd1, 1'b0, 1'b0);
    runOp("sub_wrap",  2'b10, 32'd3, 32'd5, 4'd6, 32'hFFFF_FFFE, 1'b0, 1'b0);
    runOp("illegal4",  2'b01, 32'd1, 32'd1, 4'd4, 32'd0, 1'b1, 1'b1);
    runOp("illegal15", 2'b10, 32'd5, 32'd0, 4'd15, 32'd0, 1'b1, 1'b1);

    // Backpressure: response held for five cycles while requester 1 waits.
    applyStimulus(2'b01, 32'd2, 32'd3, 4'd2, 32'd9, 32'd1, 4'd6);
    tick();
    applyStimulus(2'b10, 32'd2, 32'd3, 4'd2, 32'd9, 32'd1, 4'd6);
    tick();
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("bp_out",   rsp_out, 32'd5);
      checkOutput("bp_ready", {30'd0, req_ready}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checkOutput("bp_hs_out", rsp_out, 32'd5);
    tick();
    rsp_ready = 1'b0;
    checkOutput("bp_resume_ready", {30'd0, req_ready}, 32'd2);
    tick();
    applyStimulus(2'b00, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0);
    tick();
    checkOutput("bp_next_out", rsp_out, 32'd8);
    checkOutput("bp_next_id",  {31'd0, rsp_id}, 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Reset in EXEC drops the request and restores requester-0 priority on a tie.
    applyStimulus(2'b01, 32'd20, 32'd22, 4'd2, 32'd0, 32'd0, 4'd0);
    tick();
    applyStimulus(2'b00, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checkOutput("rexec_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rexec_out",   rsp_out, 32'd0);
    tick();
    tick();
    checkOutput("rexec_no_rsp", {31'd0, rsp_valid}, 32'd0);
    applyStimulus(2'b11, 32'd4, 32'd4, 4'd2, 32'd50, 32'd1, 4'd6);
    #1;
    checkOutput("rexec_tie_grant", {30'd0, req_ready}, 32'd1);
    tick();
    applyStimulus(2'b00, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0);
    tick();
    checkOutput("rexec_after_valid", {31'd0, rsp_valid}, 32'd1);
    checkOutput("rexec_after_out",   rsp_out, 32'd8);
    checkOutput("rexec_after_id",    {31'd0, rsp_id}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand and result width in bits.
REQ-002 The block SHALL have clock  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clock.
REQ-004 The block SHALL have req_valid  input  2  per-requester request valid (bit i = requester i).
REQ-005 The block SHALL have req_ready  output  2  per-requester accept; at most one bit high per cycle.
REQ-006 The block SHALL have req0_a, req0_b, req1_a, req1_b  input  WIDTH each  per-requester operands.
REQ-007 The block SHALL have req0_op, req1_op  input  4 each  per-requester opcode.
REQ-008 The block SHALL have rsp_valid  output  1  result available.
REQ-009 The block SHALL have rsp_ready  input  1  consumer accepts the result.
REQ-010 The block SHALL have rsp_out  output  WIDTH  result value.
REQ-011 The block SHALL have rsp_zero  output  1  high when rsp_out == 0.
REQ-012 The block SHALL have rsp_id  output  1  index of the requester that owns the result.
REQ-013 The block SHALL have rsp_err  output  1  high when the opcode was not legal.

Function
REQ-014 Opcodes SHALL be: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT; all other values are illegal.
REQ-015 ADD/SUB SHALL wrap modulo 2^WIDTH; SLT SHALL compare operands as signed two's complement, result 1 or 0 zero-extended.
REQ-016 Illegal opcode SHALL give rsp_out 0, rsp_zero 1, rsp_err 1; legal opcodes give rsp_err 0.
REQ-017 rsp_zero SHALL be computed for every opcode, not only SUB.
REQ-018 The FSM SHALL have states IDLE, EXEC, RESP; reset state IDLE.
REQ-019 IDLE: if any req_valid bit is high, req_ready SHALL go high (combinationally, same cycle) for exactly one granted requester; operands, opcode and id are captured; next state EXEC. Otherwise remain IDLE, req_ready 0.
REQ-020 req_ready SHALL be 0 in EXEC and RESP.
REQ-021 Arbitration SHALL be round-robin: a single valid requester always wins; if both valid, the requester not granted last wins; last-grant register updates on every grant.
REQ-022 EXEC: the ALU result, zero and err SHALL be registered into the response registers; next state RESP.
REQ-023 RESP: rsp_valid SHALL be 1 and rsp_out/zero/id/err SHALL hold stable until rsp_valid && rsp_ready; on that edge next state IDLE.
REQ-024 Latency: request accepted in cycle N SHALL produce rsp_valid in cycle N+2; with rsp_ready held high, back-to-back accepts occur every 3 cycles.
REQ-025 Changes on req inputs after acceptance SHALL NOT affect the pending result.
REQ-026 rsp_valid SHALL be 0 in IDLE and EXEC.

Reset
REQ-027 With reset low at a rising edge: state IDLE, rsp_valid 0, rsp_out 0, rsp_zero 0, rsp_id 0, rsp_err 0, last-grant = 1 (requester 0 wins the first tie).
REQ-028 Reset asserted in EXEC or RESP SHALL discard the in-flight operation; no response is delivered for it.
REQ-029 req_ready SHALL be 0 in any cycle where reset is low.

Structure
REQ-030 Opcode constants (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT) and the FSM state encoding SHALL live in a shared package used by the processor control path.
REQ-031 The combinational ALU function SHALL be a sub-module alu_compute (a, b, op -> out, zero, err); the arbiter holds all state.

Verification
REQ-032 Single request: req_valid=01, a=5, b=3, op=2 -> req_ready=01 in cycle N, rsp_valid at N+2 with rsp_out=8, rsp_zero=0, rsp_id=0, rsp_err=0.
REQ-033 Tie after reset: req_valid=11 held, rsp_ready=1 -> grants alternate 0,1,0,1 on accepts every 3 cycles.
REQ-034 SUB zero and SLT signed: a=7,b=7,op=6 -> rsp_out=0, rsp_zero=1; a=0xFFFFFFFF, b=1, op=7 -> rsp_out=1.
REQ-035 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_out stable, req_ready=00 throughout; accept resumes the cycle after rsp_ready=1 handshake.
REQ-036 Illegal op 4 with a=1,b=1 -> rsp_out=0, rsp_zero=1, rsp_err=1.
REQ-037 Reset low during EXEC -> next cycle IDLE, rsp_valid=0, no response for that request; following request served normally with requester 0 winning a tie.
